bsg_wormhole_age_arb: RTL and testbench
=======================================

# bsg_wormhole_age_arb

Per-output-port arbiter for the mesh router that grants the oldest requesting input by timestamp, then locks that grant for a whole multi-flit packet. Arbitration is wrap-safe, and ties on timestamp are broken round-robin. One instance sits on each router output and drives the one-hot select of that output's data/ts mux and the yumi back to the inputs. It replaces stateless single-flit age arbitration so that wormhole packets are never interleaved on an output.

## Interface
- inputs_p, 5, number of requesting input ports (1..8)
- ts_width_p, 8, timestamp width; smaller value means older, modulo 2^ts_width_p
- len_width_p, 4, width of the header body-flit count
- clk_i  input  1  clock
- reset_i  input  1  reset. One clock; reset is synchronous and active-high.
- reqs_i  input  inputs_p  per-input request (input valid and routed to this output)
- ts_i  input  inputs_p*ts_width_p  per-input head-flit timestamp
- len_i  input  inputs_p*len_width_p  per-input number of body flits following the header. Sampled only on a header grant.
- ready_i  input  1  downstream output can accept a flit this cycle
- grants_o  output  inputs_p  one-hot grant; a grant is a transfer (acts as yumi)
- v_o  output  1  OR of grants_o
- locked_o  output  1  a packet is in flight (state LOCK)
- owner_o  output  $clog2(inputs_p) (min 1)  index of the locked or most recent owner
- ts_o  output  ts_width_p  timestamp of the granted input; 0 when no grant

## Operation
- **States:** IDLE (arbitrate headers) and LOCK (stream body flits of the owner).
- **Registers:**
  - state
  - owner (index)
  - remaining (len_width_p bits)
  - rr_ptr (index, tie-break start)
- **Age compare, i older than j:**
  - d = ts_i[j] - ts_i[i], truncated to ts_width_p bits.
  - i is older if d != 0 and d[msb] == 0.
  - d == 0 or d == 2^(ts_width_p-1) is a tie.
- **Winner in IDLE:** among requesting inputs, the input that no other requester is strictly older than.
  - If several inputs qualify, pick the first at or after rr_ptr in ascending index, wrapping.
  - Non-transitive wrap cases resolve the same way (first qualifier from rr_ptr). If none qualifies, take the first requester from rr_ptr.
- **IDLE grant:**
  - grants_o = onehot(winner) when any reqs_i and ready_i; else 0.
  - On a grant with len_i[winner] == 0 (single-flit packet): stay IDLE; rr_ptr <= winner+1 mod inputs_p.
  - On a grant with len_i[winner] > 0: go to LOCK; owner <= winner; remaining <= len_i[winner].
- **LOCK:**
  - grants_o = onehot(owner) & {inputs_p{reqs_i[owner] & ready_i}}.
  - All other inputs are masked regardless of age.
  - Each grant decrements remaining.
  - On a grant with remaining == 1: go to IDLE; rr_ptr <= owner+1 mod inputs_p.
  - A missing owner request or deasserted ready_i stalls the packet with no state change; the block never times out.
- **Invariants:**
  - grants_o is one-hot or zero.
  - A grant is never asserted without ready_i.
  - A grant is never asserted to a non-requesting input.
- owner_o shows owner in LOCK, and the winner index in IDLE.
- **Reset (synchronous, at any time including mid-packet):**
  - state = IDLE, remaining = 0, owner = 0, rr_ptr = 0.
  - The next cycle arbitrates fresh.
  - A packet cut by reset is the upstream's responsibility.

## Timing
- Grant is combinational from reqs_i/ts_i/len_i/ready_i and the registered state. Grant latency is zero: a request in cycle t is granted in cycle t if it wins.
- State, remaining, owner and rr_ptr update on the rising edge after a grant.
- A packet of len L occupies the output for exactly L+1 grant cycles. With ready_i and the owner's request held high, these cycles are back-to-back.
- The first IDLE arbitration is in the cycle after the tail grant, so there is no idle bubble between packets if requests are present.
- **Reset values:**
  - grants_o = 0 while reset_i is high. Outputs are gated by reset_i.
  - v_o = 0, locked_o = 0, owner_o = 0, ts_o = 0.

## Test plan
- **Age win:**
  - Stimulus: inputs 1 and 3 request, ts = 8'h10 and 8'h0C, len 0, ready_i = 1.
  - Required: grants_o = 5'b01000, ts_o = 8'h0C.
  - Repeat with ts 8'h0C and 8'h10 swapped: grants_o = 5'b00010.
- **Wrap compare:**
  - Stimulus: ts0 = 8'hFE, ts2 = 8'h03, both requesting.
  - Required: input 0 granted, since d = 0x05 and msb 0.
  - Stimulus: ts0 = 8'h00, ts2 = 8'h80.
  - Required: tie resolved by rr_ptr.
- **Round-robin tie:**
  - Stimulus: all 5 inputs request with equal ts and len 0 for 5 cycles after reset.
  - Required: grants rotate 0,1,2,3,4. rr_ptr returns to 0.
- **Packet lock:**
  - Stimulus: input 2 wins with len 3; input 0 requests with an older ts throughout.
  - Required: grants to input 2 for 4 cycles with locked_o = 1 on cycles 2-4; input 0 is granted in cycle 5.
- **Stall in LOCK:**
  - Stimulus: mid-packet, drop ready_i for 2 cycles, then drop the owner's request for 1 cycle.
  - Required: grants_o = 0 in those cycles, remaining is unchanged, and the tail still completes after the correct flit count.
- **Reset mid-packet:**
  - Stimulus: assert reset_i with remaining = 2.
  - Required: the next cycle shows locked_o = 0, an IDLE arbitration occurs, and rr_ptr = 0 (equal-ts tie grants input 0).

Source files
------------

// File: rtl/bsg_wormhole_age_arb.sv
// Wormhole age arbiter for one router output port.
// In IDLE it grants the oldest requesting header by wrap-safe timestamp compare,
// with round-robin tie-break. In LOCK it grants only the packet owner until the
// tail flit has been sent.

// Per-input qualifier: asserted when this input requests and no other
// requester is strictly older.
module bsg_wormhole_age_arb_qual #(
  parameter int inputs_p   = 5,
  parameter int ts_width_p = 8,
  parameter int idx_p      = 0
) (
  input  logic [inputs_p-1:0]            i_reqs,
  input  logic [inputs_p*ts_width_p-1:0] i_ts,
  output logic                           o_qual
);

  logic [ts_width_p-1:0] w_d;
  logic                  w_beaten;

  // j beats idx_p when (ts[idx] - ts[j]) is nonzero with a clear msb
  always_comb begin
    w_beaten = 1'b0;
    w_d      = '0;
    for (int j = 0; j < inputs_p; j++) begin
      w_d = i_ts[idx_p*ts_width_p +: ts_width_p] - i_ts[j*ts_width_p +: ts_width_p];
      if (j != idx_p && i_reqs[j] && w_d != '0 && !w_d[ts_width_p-1])
        w_beaten = 1'b1;
    end
  end

  assign o_qual = i_reqs[idx_p] & ~w_beaten;

endmodule

module bsg_wormhole_age_arb #(
  parameter int inputs_p    = 5,
  parameter int ts_width_p  = 8,
  parameter int len_width_p = 4,
  localparam int lg_lp      = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [inputs_p-1:0]              reqs_i,
  input  logic [inputs_p*ts_width_p-1:0]   ts_i,
  input  logic [inputs_p*len_width_p-1:0]  len_i,
  input  logic                             ready_i,
  output logic [inputs_p-1:0]              grants_o,
  output logic                             v_o,
  output logic                             locked_o,
  output logic [lg_lp-1:0]                 owner_o,
  output logic [ts_width_p-1:0]            ts_o
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_e;

  state_e                 r_state;
  logic [lg_lp-1:0]       r_owner;
  logic [lg_lp-1:0]       r_rr;
  logic [len_width_p-1:0] r_rem;

  logic [inputs_p-1:0]    w_qual;
  logic [lg_lp-1:0]       w_winner;
  logic [lg_lp-1:0]       w_win_q;
  logic [lg_lp-1:0]       w_win_r;
  logic                   w_found_q;
  logic                   w_found_r;
  int                     w_idx;
  logic [inputs_p-1:0]    w_grants;
  logic [len_width_p-1:0] w_len;
  logic [ts_width_p-1:0]  w_ts;

  function automatic logic [lg_lp-1:0] f_next(input logic [lg_lp-1:0] idx);
    return (idx == lg_lp'(inputs_p-1)) ? '0 : idx + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < inputs_p; gi++) begin : g_qual
      bsg_wormhole_age_arb_qual #(
        .inputs_p  (inputs_p),
        .ts_width_p(ts_width_p),
        .idx_p     (gi)
      ) u_qual (
        .i_reqs(reqs_i),
        .i_ts  (ts_i),
        .o_qual(w_qual[gi])
      );
    end
  endgenerate

  // Scan from rr_ptr: first qualifier wins; if the wrap compare left no
  // qualifier (non-transitive cycle), fall back to the first requester.
  always_comb begin
    w_found_q = 1'b0;
    w_found_r = 1'b0;
    w_win_q   = '0;
    w_win_r   = '0;
    w_idx     = 0;
    for (int k = 0; k < inputs_p; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= inputs_p) w_idx = w_idx - inputs_p;
      if (!w_found_q && w_qual[w_idx]) begin
        w_found_q = 1'b1;
        w_win_q   = lg_lp'(w_idx);
      end
      if (!w_found_r && reqs_i[w_idx]) begin
        w_found_r = 1'b1;
        w_win_r   = lg_lp'(w_idx);
      end
    end
    w_winner = w_found_q ? w_win_q : w_win_r;
  end

  assign w_len = len_i[w_winner*len_width_p +: len_width_p];

  // Zero-latency grant; held off entirely while in reset
  always_comb begin
    w_grants = '0;
    if (!reset_i) begin
      if (r_state == S_IDLE) begin
        if (|reqs_i && ready_i) w_grants[w_winner] = 1'b1;
      end else if (reqs_i[r_owner] && ready_i) begin
        w_grants[r_owner] = 1'b1;
      end
    end
  end

  // Timestamp of whichever input is granted, zero otherwise
  always_comb begin
    w_ts = '0;
    for (int i = 0; i < inputs_p; i++)
      if (w_grants[i]) w_ts = ts_i[i*ts_width_p +: ts_width_p];
  end

  assign grants_o = w_grants;
  assign v_o      = |w_grants;
  assign ts_o     = w_ts;
  assign locked_o = ~reset_i & (r_state == S_LOCK);
  assign owner_o  = reset_i              ? '0      :
                    (r_state == S_LOCK)  ? r_owner :
                    (|reqs_i)            ? w_winner : r_owner;

  // Packet FSM: a header with body flits locks the output to its owner
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rem   <= '0;
      r_rr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_grants) begin
            if (w_len == '0) begin
              r_rr <= f_next(w_winner);
            end else begin
              r_state <= S_LOCK;
              r_owner <= w_winner;
              r_rem   <= w_len;
            end
          end
        end
        S_LOCK: begin
          if (|w_grants) begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == len_width_p'(1)) begin
              r_state <= S_IDLE;
              r_rr    <= f_next(r_owner);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_age_arb.sv
// Directed bench for bsg_wormhole_age_arb with hand-computed expectations.
module tb_bsg_wormhole_age_arb;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [4:0]      reqs_i;
  logic [4:0][7:0] ts;
  logic [4:0][3:0] len;
  logic            ready_i;
  logic [4:0]      grants_o;
  logic            v_o;
  logic            locked_o;
  logic [2:0]      owner_o;
  logic [7:0]      ts_o;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  bsg_wormhole_age_arb #(.inputs_p(5), .ts_width_p(8), .len_width_p(4)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .reqs_i  (reqs_i),
    .ts_i    (ts),
    .len_i   (len),
    .ready_i (ready_i),
    .grants_o(grants_o),
    .v_o     (v_o),
    .locked_o(locked_o),
    .owner_o (owner_o),
    .ts_o    (ts_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // grants, v_o and locked_o together
  task automatic chk_g(input string tag, input logic [4:0] eg, input logic el);
    chk({tag, ".grants"}, 32'(grants_o), 32'(eg));
    chk({tag, ".v"},      32'(v_o),      32'(|eg));
    chk({tag, ".locked"}, 32'(locked_o), 32'(el));
  endtask

  // advance one cycle; inputs change 1 time unit after the edge, checks follow
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    reqs_i  = '1;
    ts      = '0;
    len     = '0;
    ready_i = 1'b1;
    tick();
    #2;
    chk_g("reset", 5'b00000, 1'b0);
    chk("reset.owner", 32'(owner_o), 0);
    chk("reset.ts", 32'(ts_o), 0);
    tick();
    reset_i = 1'b0;
    reqs_i  = '0;

    // Age win: 3 (0x0C) older than 1 (0x10); rr -> 4
    reqs_i = 5'b01010; ts[1] = 8'h10; ts[3] = 8'h0C;
    #2;
    chk_g("age_a", 5'b01000, 1'b0);
    chk("age_a.ts", 32'(ts_o), 32'h0C);
    chk("age_a.owner", 32'(owner_o), 3);
    tick();
    // Swapped timestamps; rr -> 2
    ts[1] = 8'h0C; ts[3] = 8'h10;
    #2;
    chk_g("age_b", 5'b00010, 1'b0);
    chk("age_b.ts", 32'(ts_o), 32'h0C);
    tick();

    // Wrap compare: 0xFE older than 0x03; rr -> 1
    reqs_i = 5'b00101; ts[0] = 8'hFE; ts[2] = 8'h03;
    #2;
    chk_g("wrap", 5'b00001, 1'b0);
    chk("wrap.ts", 32'(ts_o), 32'hFE);
    tick();
    // Half-range distance is a tie: rr=1 -> input 2; then rr=3 -> input 0
    ts[0] = 8'h00; ts[2] = 8'h80;
    #2;
    chk_g("tie_a", 5'b00100, 1'b0);
    tick();
    #2;
    chk_g("tie_b", 5'b00001, 1'b0);
    tick();

    // Round-robin after reset, all equal timestamps
    reset_i = 1'b1; reqs_i = '0;
    tick();
    reset_i = 1'b0;
    reqs_i = 5'b11111; ts = {5{8'h20}}; len = '0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk_g($sformatf("rr%0d", k), 5'(1 << k), 1'b0);
      tick();
    end
    #2;
    chk_g("rr_wrap", 5'b00001, 1'b0);
    tick();   // rr -> 1

    // Packet lock: input 2 header with len 3, then older input 0 is masked
    reqs_i = 5'b00100; ts[2] = 8'h50; len[2] = 4'd3;
    #2;
    chk_g("pkt_hdr", 5'b00100, 1'b0);
    tick();
    reqs_i = 5'b00101; ts[0] = 8'h40; len[0] = 4'd0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk_g($sformatf("pkt_body%0d", k), 5'b00100, 1'b1);
      chk($sformatf("pkt_owner%0d", k), 32'(owner_o), 2);
      chk($sformatf("pkt_ts%0d", k), 32'(ts_o), 32'h50);
      tick();
    end
    #2;
    chk_g("pkt_next", 5'b00001, 1'b0);
    tick();   // rr -> 1

    // Stall in LOCK: input 1, len 2
    reqs_i = 5'b00010; len[1] = 4'd2; len[3] = 4'd0;
    #2;
    chk_g("st_hdr", 5'b00010, 1'b0);
    tick();
    #2;
    chk_g("st_body", 5'b00010, 1'b1);
    tick();   // remaining = 1
    ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk_g($sformatf("st_noready%0d", k), 5'b00000, 1'b1);
      tick();
    end
    ready_i = 1'b1; reqs_i = 5'b01000;
    #2;
    chk_g("st_noreq", 5'b00000, 1'b1);
    chk("st_noreq.owner", 32'(owner_o), 1);
    tick();
    reqs_i = 5'b01010;
    #2;
    chk_g("st_tail", 5'b00010, 1'b1);
    tick();   // IDLE, rr -> 2
    reqs_i = 5'b01000;
    #2;
    chk_g("st_after", 5'b01000, 1'b0);
    tick();

    // Reset mid-packet: input 4, len 3, reset with remaining = 2
    reqs_i = 5'b10000; len[4] = 4'd3;
    #2;
    chk_g("rst_hdr", 5'b10000, 1'b0);
    tick();
    #2;
    chk_g("rst_body", 5'b10000, 1'b1);
    tick();
    reset_i = 1'b1;
    #2;
    chk_g("rst_hold", 5'b00000, 1'b0);
    chk("rst_hold.ts", 32'(ts_o), 0);
    tick();
    reset_i = 1'b0;
    reqs_i = 5'b11111; ts = {5{8'h33}}; len = '0;
    #2;
    chk_g("rst_fresh", 5'b00001, 1'b0);
    chk("rst_fresh.owner", 32'(owner_o), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
